// File: rtl/uart_transceiver.sv
`timescale 1ns/1ps
// uart_transceiver
// Full-duplex UART with elaboration-time frame format: DATA_BITS data bits
// (LSB first), optional odd/even parity and one or two transmitted stop bits.
// Bit period is CPB = CLK_HZ / BAUD_RATE clock cycles.
//
// Ports:
//   clk_in, rst_n_in          system clock, asynchronous active-low reset
//   tx_data_in/tx_valid_in    word to send, taken when tx_ready_out is high
//   tx_ready_out              transmitter idle
//   tx_wire_out               serial TX line, idle high
//   rx_wire_in                serial RX line, asynchronous to clk_in
//   rx_data_out               last received word (held between pulses)
//   rx_valid_out              one-cycle pulse per received frame
//   rx_parity_err_out         parity mismatch on the pulsed frame
//   rx_frame_err_out          first stop bit sampled low on the pulsed frame
//   loopback_in               only when UART_LOOPBACK_EN is defined: routes the
//                             internal TX bit into the receiver and holds
//                             tx_wire_out high
//
// Optional build macro: UART_LOOPBACK_EN
module uart_transceiver #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback_in,
`endif
  input  logic [DATA_BITS-1:0] tx_data_in,
  input  logic                 tx_valid_in,
  output logic                 tx_ready_out,
  output logic                 tx_wire_out,
  input  logic                 rx_wire_in,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_valid_out,
  output logic                 rx_parity_err_out,
  output logic                 rx_frame_err_out
);

  localparam int CPB   = CLK_HZ / BAUD_RATE;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(STOP_BITS * CPB) + 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  generate
    if (CPB < 4) begin : g_bad_cpb
      $error("uart_transceiver: CLK_HZ/BAUD_RATE must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
      $error("uart_transceiver: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_transceiver: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_transceiver: STOP_BITS must be 1 or 2");
    end
  endgenerate

  logic loopback_active;
`ifdef UART_LOOPBACK_EN
  assign loopback_active = loopback_in;
`else
  assign loopback_active = 1'b0;
`endif

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  tx_state_t              tx_state_reg;
  logic [CNT_W-1:0]       tx_cnt_reg;
  logic [IDX_W-1:0]       tx_idx_reg;
  logic [DATA_BITS-1:0]   tx_shift_reg;
  logic                   tx_par_reg;
  logic                   tx_wire_reg;
  logic                   tx_ready_reg;

  // Every bit boundary lands on an edge t0 + k*CPB after the accepting edge:
  // the counter is loaded with CPB-1 and the next bit is driven when it hits 0.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_idx_reg   <= '0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      tx_wire_reg  <= 1'b1;
      tx_ready_reg <= 1'b0;
    end else if (tx_state_reg == TX_IDLE) begin
      if (!tx_ready_reg) begin
        // only reachable straight after reset release
        tx_ready_reg <= 1'b1;
      end else if (tx_valid_in) begin
        tx_shift_reg <= tx_data_in;
        tx_par_reg   <= (PARITY == 1) ? ~^tx_data_in : ^tx_data_in;
        tx_wire_reg  <= 1'b0;
        tx_ready_reg <= 1'b0;
        tx_cnt_reg   <= CNT_W'(CPB - 1);
        tx_state_reg <= TX_START;
      end
    end else if (tx_cnt_reg != '0) begin
      tx_cnt_reg <= tx_cnt_reg - 1'b1;
    end else begin
      case (tx_state_reg)
        TX_START: begin
          tx_wire_reg  <= tx_shift_reg[0];
          tx_shift_reg <= tx_shift_reg >> 1;
          tx_idx_reg   <= '0;
          tx_cnt_reg   <= CNT_W'(CPB - 1);
          tx_state_reg <= TX_DATA;
        end
        TX_DATA: begin
          if (tx_idx_reg == IDX_W'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              tx_wire_reg  <= tx_par_reg;
              tx_cnt_reg   <= CNT_W'(CPB - 1);
              tx_state_reg <= TX_PARITY;
            end else begin
              tx_wire_reg  <= 1'b1;
              tx_cnt_reg   <= CNT_W'(STOP_BITS * CPB - 1);
              tx_state_reg <= TX_STOP;
            end
          end else begin
            tx_wire_reg  <= tx_shift_reg[0];
            tx_shift_reg <= tx_shift_reg >> 1;
            tx_idx_reg   <= tx_idx_reg + 1'b1;
            tx_cnt_reg   <= CNT_W'(CPB - 1);
          end
        end
        TX_PARITY: begin
          tx_wire_reg  <= 1'b1;
          tx_cnt_reg   <= CNT_W'(STOP_BITS * CPB - 1);
          tx_state_reg <= TX_STOP;
        end
        TX_STOP: begin
          tx_ready_reg <= 1'b1;
          tx_state_reg <= TX_IDLE;
        end
        default: tx_state_reg <= TX_IDLE;
      endcase
    end
  end

  assign tx_ready_out = tx_ready_reg;
  assign tx_wire_out  = tx_wire_reg | loopback_active;

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE} rx_state_t;

  logic                   rx_line;
  logic                   rx_sync1_reg;
  logic                   rx_sync2_reg;
  rx_state_t              rx_state_reg;
  logic [CNT_W-1:0]       rx_cnt_reg;
  logic [IDX_W-1:0]       rx_idx_reg;
  logic [DATA_BITS-1:0]   rx_shift_reg;
  logic                   rx_par_reg;
  logic [DATA_BITS-1:0]   rx_data_reg;
  logic                   rx_valid_reg;
  logic                   rx_perr_reg;
  logic                   rx_ferr_reg;

  assign rx_line = loopback_active ? tx_wire_reg : rx_wire_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_sync1_reg <= 1'b1;
      rx_sync2_reg <= 1'b1;
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_idx_reg   <= '0;
      rx_shift_reg <= '0;
      rx_par_reg   <= 1'b0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      rx_perr_reg  <= 1'b0;
      rx_ferr_reg  <= 1'b0;
    end else begin
      rx_sync1_reg <= rx_line;
      rx_sync2_reg <= rx_sync1_reg;
      rx_valid_reg <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: begin
          if (!rx_sync2_reg) begin
            rx_cnt_reg   <= CNT_W'(HALF - 1);
            rx_state_reg <= RX_START;
          end
        end
        // after a break, hold off until the line is released so one long
        // low period yields exactly one (errored) frame
        RX_WAIT_IDLE: begin
          if (rx_sync2_reg) rx_state_reg <= RX_IDLE;
        end
        default: begin
          if (rx_cnt_reg != '0) begin
            rx_cnt_reg <= rx_cnt_reg - 1'b1;
          end else begin
            case (rx_state_reg)
              RX_START: begin
                if (rx_sync2_reg) begin
                  rx_state_reg <= RX_IDLE;  // glitch shorter than half a bit
                end else begin
                  rx_idx_reg   <= '0;
                  rx_cnt_reg   <= CNT_W'(CPB - 1);
                  rx_state_reg <= RX_DATA;
                end
              end
              RX_DATA: begin
                rx_shift_reg <= {rx_sync2_reg, rx_shift_reg[DATA_BITS-1:1]};
                rx_cnt_reg   <= CNT_W'(CPB - 1);
                if (rx_idx_reg == IDX_W'(DATA_BITS - 1))
                  rx_state_reg <= (PARITY != 0) ? RX_PARITY : RX_STOP;
                else
                  rx_idx_reg <= rx_idx_reg + 1'b1;
              end
              RX_PARITY: begin
                rx_par_reg   <= rx_sync2_reg;
                rx_cnt_reg   <= CNT_W'(CPB - 1);
                rx_state_reg <= RX_STOP;
              end
              RX_STOP: begin
                rx_valid_reg <= 1'b1;
                rx_data_reg  <= rx_shift_reg;
                // odd mode expects the XOR of data and parity to be 1
                rx_perr_reg  <= (PARITY != 0) &&
                                ((^rx_shift_reg ^ rx_par_reg) != (PARITY == 1));
                rx_ferr_reg  <= ~rx_sync2_reg;
                rx_state_reg <= rx_sync2_reg ? RX_IDLE : RX_WAIT_IDLE;
              end
              default: rx_state_reg <= RX_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign rx_data_out       = rx_data_reg;
  assign rx_valid_out      = rx_valid_reg;
  assign rx_parity_err_out = rx_perr_reg;
  assign rx_frame_err_out  = rx_ferr_reg;

endmodule

// File: tb/tb_uart_transceiver.sv
`timescale 1ns/1ps
// Directed bench for uart_transceiver.
//   dut_a: default build (CPB = 868, 8N1), exercises TX timing and reset abort.
//   dut_b: CPB = 32, 8 data bits, even parity, exercises the receiver
//          (and loopback when UART_LOOPBACK_EN is defined).
module tb_uart_transceiver;

  localparam int CPB_A = 868;
  localparam int CPB_B = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [7:0] tx_data_a;
  logic       tx_valid_a, tx_ready_a, tx_wire_a;
  logic [7:0] rx_data_a;
  logic       rx_valid_a, perr_a, ferr_a;

  logic [7:0] tx_data_b;
  logic       tx_valid_b, tx_ready_b, tx_wire_b, rx_wire_b;
  logic [7:0] rx_data_b;
  logic       rx_valid_b, perr_b, ferr_b;
`ifdef UART_LOOPBACK_EN
  logic       loop_a, loop_b;
`endif

  uart_transceiver dut_a (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
`ifdef UART_LOOPBACK_EN
    .loopback_in       (loop_a),
`endif
    .tx_data_in        (tx_data_a),
    .tx_valid_in       (tx_valid_a),
    .tx_ready_out      (tx_ready_a),
    .tx_wire_out       (tx_wire_a),
    .rx_wire_in        (1'b1),
    .rx_data_out       (rx_data_a),
    .rx_valid_out      (rx_valid_a),
    .rx_parity_err_out (perr_a),
    .rx_frame_err_out  (ferr_a)
  );

  uart_transceiver #(
    .CLK_HZ    (CPB_B * 115_200),
    .BAUD_RATE (115_200),
    .DATA_BITS (8),
    .PARITY    (2),
    .STOP_BITS (1)
  ) dut_b (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
`ifdef UART_LOOPBACK_EN
    .loopback_in       (loop_b),
`endif
    .tx_data_in        (tx_data_b),
    .tx_valid_in       (tx_valid_b),
    .tx_ready_out      (tx_ready_b),
    .tx_wire_out       (tx_wire_b),
    .rx_wire_in        (rx_wire_b),
    .rx_data_out       (rx_data_b),
    .rx_valid_out      (rx_valid_b),
    .rx_parity_err_out (perr_b),
    .rx_frame_err_out  (ferr_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // receive-pulse monitors, sampled on the falling edge
  int         pulses_a = 0;
  int         pulses_b = 0;
  logic [7:0] cap_data = 8'h00;
  logic       cap_perr = 1'b0;
  logic       cap_ferr = 1'b0;

  always @(negedge clk) begin
    if (rx_valid_a) pulses_a++;
    if (rx_valid_b) begin
      pulses_b++;
      cap_data = rx_data_b;
      cap_perr = perr_b;
      cap_ferr = ferr_b;
      $display("rx frame: data=0x%02h parity_err=%0b frame_err=%0b", rx_data_b, perr_b, ferr_b);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // serial frame into dut_b: start, 8 data LSB first, parity, stop
  task automatic send_frame_b(input logic [7:0] d, input logic par, input logic stop);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int k = 0; k < 11; k++) begin
      rx_wire_b = bits[k];
      repeat (CPB_B) @(negedge clk);
    end
  endtask

  int         base;
  int         low_cnt;
  int         bad_bits;
  int         zeros;
  logic [9:0] fbits;

  initial begin
    rst_n      = 1'b0;
    tx_data_a  = 8'h00;
    tx_valid_a = 1'b0;
    tx_data_b  = 8'h00;
    tx_valid_b = 1'b0;
    rx_wire_b  = 1'b1;
`ifdef UART_LOOPBACK_EN
    loop_a = 1'b0;
    loop_b = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // ---- reset state
    check("rst_tx_ready",   32'(tx_ready_a), 32'd0);
    check("rst_tx_wire",    32'(tx_wire_a),  32'd1);
    check("rst_tx_wire_b",  32'(tx_wire_b),  32'd1);
    check("rst_rx_valid_a", 32'(rx_valid_a), 32'd0);
    check("rst_rx_data_a",  32'(rx_data_a),  32'd0);
    check("rst_perr_a",     32'(perr_a),     32'd0);
    check("rst_ferr_a",     32'(ferr_a),     32'd0);
    check("rst_rx_data_b",  32'(rx_data_b),  32'd0);
    rst_n = 1'b1;
    #1 check("ready_before_edge", 32'(tx_ready_a), 32'd0);
    @(negedge clk);
    check("ready_after_edge", 32'(tx_ready_a), 32'd1);

    // ---- 1: send 0xA5, then a second word back-to-back
    fbits = {1'b1, 8'hA5, 1'b0};
    tx_data_a  = 8'hA5;
    tx_valid_a = 1'b1;
    @(posedge clk);
    low_cnt  = 0;
    bad_bits = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (tx_ready_a) break;
      low_cnt++;
      if (i == 5000) tx_data_a = 8'h34;  // changes while busy must not matter
      if (tx_wire_a !== fbits[i / CPB_A]) bad_bits++;
    end
    $display("tx frame 0xA5: ready low %0d cycles, bit errors %0d", low_cnt, bad_bits);
    check("tx_busy_cycles", 32'(low_cnt),  32'd8680);
    check("tx_bit_errors",  32'(bad_bits), 32'd0);
    @(negedge clk);
    check("second_accept_ready", 32'(tx_ready_a), 32'd0);
    check("second_accept_start", 32'(tx_wire_a),  32'd0);
    tx_valid_a = 1'b0;

    // ---- 5: reset during data bit 3 of 0x34 (bit 3 = 0)
    repeat (4 * CPB_A + 400) @(negedge clk);
    check("tx_bit3_value", 32'(tx_wire_a), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_wire",  32'(tx_wire_a),  32'd1);
    check("abort_ready", 32'(tx_ready_a), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("abort_ready_release", 32'(tx_ready_a), 32'd0);
    @(negedge clk);
    check("abort_ready_up", 32'(tx_ready_a), 32'd1);
    zeros = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tx_wire_a !== 1'b1) zeros++;
    end
    $display("tx after abort: %0d low cycles on line", zeros);
    check("abort_no_residue", 32'(zeros), 32'd0);

    // ---- 2: even parity frames into dut_b
    check("rx_b_tx_ready_idle", 32'(tx_ready_b), 32'd1);
    base = pulses_b;
    send_frame_b(8'h3C, 1'b0, 1'b1);
    repeat (CPB_B) @(negedge clk);
    check("par_ok_pulses", 32'(pulses_b - base), 32'd1);
    check("par_ok_data",   32'(cap_data), 32'h3C);
    check("par_ok_perr",   32'(cap_perr), 32'd0);
    check("par_ok_ferr",   32'(cap_ferr), 32'd0);
    check("par_ok_hold",   32'(rx_data_b), 32'h3C);

    base = pulses_b;
    send_frame_b(8'h3C, 1'b1, 1'b1);
    repeat (CPB_B) @(negedge clk);
    check("par_bad_pulses", 32'(pulses_b - base), 32'd1);
    check("par_bad_data",   32'(cap_data), 32'h3C);
    check("par_bad_perr",   32'(cap_perr), 32'd1);
    check("par_bad_ferr",   32'(cap_ferr), 32'd0);
    check("par_bad_hold",   32'(perr_b),   32'd1);

    // ---- 3: false start shorter than half a bit
    base = pulses_b;
    rx_wire_b = 1'b0;
    repeat (CPB_B / 2 - 6) @(negedge clk);
    rx_wire_b = 1'b1;
    repeat (3 * CPB_B) @(negedge clk);
    check("false_start_pulses", 32'(pulses_b - base), 32'd0);
    send_frame_b(8'h12, 1'b0, 1'b1);
    repeat (CPB_B) @(negedge clk);
    check("after_false_pulses", 32'(pulses_b - base), 32'd1);
    check("after_false_data",   32'(cap_data), 32'h12);
    check("after_false_perr",   32'(cap_perr), 32'd0);
    check("after_false_ferr",   32'(cap_ferr), 32'd0);

    // ---- 4: framing error followed by a long break
    base = pulses_b;
    send_frame_b(8'h55, 1'b0, 1'b0);
    repeat (20000) @(negedge clk);
    check("break_pulses", 32'(pulses_b - base), 32'd1);
    check("break_data",   32'(cap_data), 32'h55);
    check("break_ferr",   32'(cap_ferr), 32'd1);
    check("break_perr",   32'(cap_perr), 32'd0);
    rx_wire_b = 1'b1;
    repeat (2 * CPB_B) @(negedge clk);
    base = pulses_b;
    send_frame_b(8'h81, 1'b0, 1'b1);
    repeat (CPB_B) @(negedge clk);
    check("recover_pulses", 32'(pulses_b - base), 32'd1);
    check("recover_data",   32'(cap_data), 32'h81);
    check("recover_perr",   32'(cap_perr), 32'd0);
    check("recover_ferr",   32'(cap_ferr), 32'd0);

`ifdef UART_LOOPBACK_EN
    // ---- 6: loopback; the external RX line is held low and must be ignored
    loop_b    = 1'b1;
    rx_wire_b = 1'b0;
    base      = pulses_b;
    tx_data_b  = 8'h7E;
    tx_valid_b = 1'b1;
    @(negedge clk);
    tx_valid_b = 1'b0;
    zeros = 0;
    for (int i = 0; i < 14 * CPB_B; i++) begin
      @(negedge clk);
      if (tx_wire_b !== 1'b1) zeros++;
    end
    check("loop_wire_high", 32'(zeros), 32'd0);
    check("loop_pulses",    32'(pulses_b - base), 32'd1);
    check("loop_data",      32'(cap_data), 32'h7E);
    check("loop_perr",      32'(cap_perr), 32'd0);
    check("loop_ferr",      32'(cap_ferr), 32'd0);
    rx_wire_b = 1'b1;
    repeat (4) @(negedge clk);
    loop_b = 1'b0;
`endif

    check("dut_a_no_rx", 32'(pulses_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
Parametrised full-duplex UART for host links such as the keychain command channel, replacing fixed 8N1 serial handling.
- TX: valid/ready byte interface serialising onto tx_wire_out.
- RX: synchronised, mid-bit-sampled deserialiser with per-frame parity and framing error flags.
- Configurable data width, parity mode and stop-bit count, all set at elaboration.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 115_200, line rate; CPB = CLK_HZ / BAUD_RATE (floor); elaboration error if CPB < 4
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits transmitted, 1 or 2

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous reset, active-low
tx_data_in  input  DATA_BITS  byte to transmit
tx_valid_in  input  1  tx_data_in valid
tx_ready_out  output  1  transmitter idle, can accept a word
tx_wire_out  output  1  serial TX line, idle high
rx_wire_in  input  1  serial RX line, asynchronous to clk_in
rx_data_out  output  DATA_BITS  last received word
rx_valid_out  output  1  one-cycle pulse, rx_data_out and error flags valid
rx_parity_err_out  output  1  parity mismatch on the pulsed frame (0 when PARITY = 0)
rx_frame_err_out  output  1  first stop bit sampled low on the pulsed frame

Behaviour:
Reset (asynchronous, while rst_n_in low):
- tx_wire_out = 1, tx_ready_out = 0.
- rx_valid_out, rx_data_out, rx_parity_err_out and rx_frame_err_out = 0.
- RX synchroniser flops = 1; both FSMs in IDLE; all counters = 0.
- tx_ready_out rises on the first clk_in edge after release.
- Reset asserted mid-frame aborts the frame immediately; no partial output.

TX FSM (IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE):
- A word is accepted when tx_valid_in & tx_ready_out at a rising edge. tx_data_in is captured and tx_ready_out falls on that edge.
- tx_wire_out drives the start bit (0) from the accepting edge.
- Each bit lasts exactly CPB cycles. Data is sent LSB first.
- Parity bit: odd mode makes total ones (data + parity) odd; even mode makes it even. No parity bit is sent when PARITY = 0.
- STOP drives 1 for STOP_BITS*CPB cycles, then the FSM returns to IDLE with tx_ready_out = 1.
- tx_ready_out is low for exactly (1 + DATA_BITS + (PARITY != 0) + STOP_BITS)*CPB cycles.
- tx_valid_in while busy is ignored. tx_data_in changes while busy have no effect.

RX path:
- rx_wire_in passes through a 2-flop synchroniser; all RX decisions use the synchronised value (2-cycle latency).
- RX FSM (IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or WAIT_IDLE).
- IDLE: a synchronised 0 starts a CPB/2 countdown.
- START: at the midpoint, a resample of 1 is a false start; return to IDLE with no output.
- DATA / PARITY: sample every CPB cycles from the start midpoint, LSB first.
- STOP: sample the first stop bit only; the receiver always accepts 1 stop bit.
- On the stop-bit sample cycle+1: rx_valid_out pulses for 1 cycle. rx_data_out updates on the same edge and holds until the next pulse. Both error flags are valid with the pulse and hold with rx_data_out.
- Stop sampled 0: flag rx_frame_err_out, then go to WAIT_IDLE. Stay there until the synchronised line is 1, so a break generates exactly one frame.
- No backpressure: the consumer must take rx_valid_out on the pulse cycle.
- TX and RX are fully independent; simultaneous activity is allowed.

Optional Feature:
UART_LOOPBACK_EN
- Defined: adds input port loopback_in (1 bit).
  - While loopback_in = 1: the RX synchroniser input is the internal TX serial bit and tx_wire_out is forced to 1.
  - While loopback_in = 0: normal operation.
  - Change loopback_in only while both FSMs are idle.
- Undefined: port absent; RX always uses rx_wire_in.

Test Plan:
1. Defaults (CPB = 868, 8N1), send 0xA5 -> tx_wire_out bits 0,1,0,1,0,0,1,0,1,1, 868 cycles each; tx_ready_out low for 8680 cycles; second word accepted on the first ready-high cycle.
2. PARITY = 2, drive frame 0x3C with parity bit 0 -> rx_valid_out pulse, rx_data_out 0x3C, both error flags 0. Repeat with parity bit 1 -> rx_parity_err_out = 1.
3. Drive rx_wire_in low for 300 cycles then high -> no rx_valid_out; a following valid frame 0x12 is received correctly.
4. Frame 0x55 with stop bit 0, line then held low 20000 cycles -> exactly one pulse with rx_frame_err_out = 1; next frame 0x81 after line returns high is received with no errors.
5. Assert rst_n_in during TX data bit 3 -> tx_wire_out = 1 and tx_ready_out = 0 immediately; tx_ready_out = 1 one edge after release; no residual bits on the line.
6. With UART_LOOPBACK_EN defined, loopback_in = 1, send 0x7E -> rx_valid_out with 0x7E and no errors; tx_wire_out stays 1 for the whole frame.
